// File: rtl/swspi_host.sv
// SPI host for the 10-bit software-interface command port: one {op, data} word
// per frame, MSB first, with the returned byte captured from MISO rises 3..10.
module swspi_host #(
  parameter int HALF_PERIOD = 8,
  parameter int SETUP       = 8,
  parameter int GAP         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       spi_sck,
  output logic       spi_ssel,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  if (HALF_PERIOD < 4) begin : g_bad_half_period
    $error("swspi_host: HALF_PERIOD must be 4 or more");
  end
  if (SETUP < 2) begin : g_bad_setup
    $error("swspi_host: SETUP must be 2 or more");
  end
  if (GAP < 4) begin : g_bad_gap
    $error("swspi_host: GAP must be 4 or more");
  end

  localparam int CNT_MAX = (SETUP > GAP) ? ((SETUP > HALF_PERIOD) ? SETUP : HALF_PERIOD)
                                         : ((GAP > HALF_PERIOD) ? GAP : HALF_PERIOD);
  localparam int CW = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  // GAP ends one cycle early so the registered cmd_ready is already high at the
  // edge GAP cycles after SSEL rises; a held command is accepted on that edge.
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          miso_s1;
  logic          miso_s2;

  // NOTE: every flop here uses <= so all updates see the values from before the
  // edge; blocking assignments would make the synchroniser collapse to one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      spi_sck   <= 1'b0;
      spi_ssel  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_SETUP;
            cmd_ready <= 1'b0;
            spi_ssel  <= 1'b0;
            tx_sh     <= {cmd_op, cmd_data};
            spi_mosi  <= cmd_op[1];
            cnt       <= '0;
            bit_cnt   <= '0;
          end
        end

        // Rise 1 happens on the SETUP exit edge; its MISO sample is discarded.
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            spi_sck <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            spi_sck <= ~spi_sck;
            if (spi_sck) begin
              if (bit_cnt == 4'd9) begin
                state    <= ST_HOLD;
                spi_mosi <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                tx_sh    <= {tx_sh[8:0], 1'b0};
                spi_mosi <= tx_sh[8];
              end
            end else if (bit_cnt >= 4'd2) begin
              rx_sh <= {rx_sh[6:0], miso_s2};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == HALF_LAST) begin
            state     <= ST_GAP;
            cnt       <= '0;
            spi_ssel  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swspi_host.sv
// Bench for swspi_host: default-parameter host against a memory device model, and
// a fast-parameter host against a fixed-byte device that answers one cycle late.
module tb_swspi_host;

  localparam logic [7:0] DEV_B_BYTE = 8'hB4;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid_a, cmd_valid_b;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  logic       cmd_ready_a, rsp_valid_a, sck_a, ssel_a, mosi_a, miso_a;
  logic [7:0] rsp_data_a;
  logic       cmd_ready_b, rsp_valid_b, sck_b, ssel_b, mosi_b, miso_b;
  logic [7:0] rsp_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  swspi_host u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .spi_sck(sck_a), .spi_ssel(ssel_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  swspi_host #(.HALF_PERIOD(4), .SETUP(2), .GAP(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .spi_sck(sck_b), .spi_ssel(ssel_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: words the device must receive, bytes the host must return.
  logic [9:0] q_word_a[$], q_word_b[$];
  logic [7:0] q_rsp_a[$],  q_rsp_b[$];
  int         n_exp_a = 0, n_exp_b = 0;
  int         n_rsp_a = 0, n_rsp_b = 0;

  // Reference view of the device, advanced as each command is issued.
  logic [7:0] ref_mem[256];
  logic [7:0] ref_addr = 8'h00;

  // Device A: memory/program store with auto-incrementing address.
  logic [7:0] dev_mem[256];
  logic [7:0] dev_prog[256];
  logic [7:0] dev_addr = 8'h00;
  logic [9:0] dev_sh_a = '0;
  logic [7:0] dev_out_a = '0;
  int         dev_rises_a = 0;

  always @(negedge ssel_a) begin
    dev_rises_a = 0;
    miso_a = 1'b0;
  end

  always @(posedge sck_a) begin
    dev_sh_a = {dev_sh_a[8:0], mosi_a};
    dev_rises_a++;
    if (dev_rises_a == 2) dev_out_a = dev_mem[dev_addr];
    if (dev_rises_a >= 2 && dev_rises_a <= 9) begin
      #1;
      miso_a = dev_out_a[7];
      dev_out_a = {dev_out_a[6:0], 1'b0};
    end
  end

  always @(posedge ssel_a) begin
    if (dev_rises_a == 10) begin
      check("word_a_queued", q_word_a.size() != 0, 1);
      if (q_word_a.size() != 0) check("word_a", dev_sh_a, q_word_a.pop_front());
      case (dev_sh_a[9:8])
        2'b00: dev_addr = dev_sh_a[7:0];
        2'b01: begin dev_prog[dev_addr] = dev_sh_a[7:0]; dev_addr++; end
        2'b10: dev_addr++;
        default: begin dev_mem[dev_addr] = dev_sh_a[7:0]; dev_addr++; end
      endcase
    end
  end

  // Device B: fixed reply byte, MISO updated one clk cycle after each SCK rise.
  logic [9:0] dev_sh_b = '0;
  logic [7:0] dev_out_b = '0;
  int         dev_rises_b = 0;

  always @(negedge ssel_b) begin
    dev_rises_b = 0;
    miso_b = 1'b0;
  end

  always @(posedge sck_b) begin
    dev_sh_b = {dev_sh_b[8:0], mosi_b};
    dev_rises_b++;
    if (dev_rises_b == 2) dev_out_b = DEV_B_BYTE;
    if (dev_rises_b >= 2 && dev_rises_b <= 9) begin
      @(posedge clk);
      #1;
      miso_b = dev_out_b[7];
      dev_out_b = {dev_out_b[6:0], 1'b0};
    end
  end

  always @(posedge ssel_b) begin
    if (dev_rises_b == 10) begin
      check("word_b_queued", q_word_b.size() != 0, 1);
      if (q_word_b.size() != 0) check("word_b", dev_sh_b, q_word_b.pop_front());
    end
  end

  // Response monitors pop the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (rsp_valid_a === 1'b1) begin
      n_rsp_a++;
      check("rsp_a_expected", q_rsp_a.size() != 0, 1);
      if (q_rsp_a.size() != 0) check("rsp_data_a", rsp_data_a, q_rsp_a.pop_front());
    end
    if (rsp_valid_b === 1'b1) begin
      n_rsp_b++;
      check("rsp_b_expected", q_rsp_b.size() != 0, 1);
      if (q_rsp_b.size() != 0) check("rsp_data_b", rsp_data_b, q_rsp_b.pop_front());
    end
  end

  // Length of the most recent SSEL-high stretch on host A, in clk cycles.
  int hi_run = 0;
  int min_gap = 1000;
  always @(negedge clk) begin
    if (ssel_a === 1'b1) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic push_expect(input bit b, input logic [1:0] op, input logic [7:0] data);
    if (b) begin
      q_word_b.push_back({op, data});
      q_rsp_b.push_back(DEV_B_BYTE);
      n_exp_b++;
    end else begin
      q_word_a.push_back({op, data});
      q_rsp_a.push_back(ref_mem[ref_addr]);
      n_exp_a++;
      case (op)
        2'b00: ref_addr = data;
        2'b01: ref_addr++;
        2'b10: ref_addr++;
        default: begin ref_mem[ref_addr] = data; ref_addr++; end
      endcase
    end
  endtask

  task automatic wait_ready(input bit b);
    int n;
    n = 0;
    while (((b ? cmd_ready_b : cmd_ready_a) !== 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", n < 1000, 1);
  endtask

  // Runs one frame; cycle numbers are counted from the accepting edge t0.
  task automatic frame(input bit b, input logic [1:0] op, input logic [7:0] data,
                       output int ssel_low, output int rises, output int rsp_at,
                       output int accept_next, output int sck_period);
    int  r1, r2;
    bit  prev_sck, s, k, rv, rdy;
    wait_ready(b);
    push_expect(b, op, data);
    cmd_op = op;
    cmd_data = data;
    if (b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_op = ~op;
    cmd_data = ~data;
    ssel_low = 0; rises = 0; rsp_at = -1; accept_next = -1; r1 = -1; r2 = -1;
    prev_sck = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (n > 0) @(negedge clk);
      s   = b ? ssel_b : ssel_a;
      k   = b ? sck_b : sck_a;
      rv  = b ? rsp_valid_b : rsp_valid_a;
      rdy = b ? cmd_ready_b : cmd_ready_a;
      if (!s) ssel_low++;
      if (k && !prev_sck) begin
        rises++;
        if (rises == 1) r1 = n;
        if (rises == 2) r2 = n;
      end
      prev_sck = k;
      if (rv) rsp_at = n;
      if (rdy) begin
        accept_next = n + 1;
        break;
      end
    end
    sck_period = r2 - r1;
  endtask

  int     ssel_low, rises, rsp_at, accept_next, sck_period;
  longint acc_t[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i]  = 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
      dev_prog[i] = 8'h00;
    end
    reset_n = 1'b0;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset_ssel", ssel_a, 1);
    check("reset_sck", sck_a, 0);
    check("reset_mosi", mosi_a, 0);
    check("reset_cmd_ready", cmd_ready_a, 1);
    check("reset_rsp_valid", rsp_valid_a, 0);
    check("reset_rsp_data", rsp_data_a, 8'h00);

    // Basic frame timing with defaults.
    frame(1'b0, 2'b00, 8'hA5, ssel_low, rises, rsp_at, accept_next, sck_period);
    check("a5_sck_rises", rises, 10);
    check("a5_ssel_low_cycles", ssel_low, 168);
    check("a5_rsp_valid_at", rsp_at, 168);
    check("a5_next_accept_edge", accept_next, 184);
    check("a5_sck_period", sck_period, 16);
    check("a5_mosi_idle_after", mosi_a, 0);

    // Fixed read byte from the device.
    frame(1'b0, 2'b00, 8'h40, ssel_low, rises, rsp_at, accept_next, sck_period);
    dev_mem[8'h40] = 8'h3C;
    ref_mem[8'h40] = 8'h3C;
    frame(1'b0, 2'b10, 8'hFF, ssel_low, rises, rsp_at, accept_next, sck_period);
    check("read_3c", rsp_data_a, 8'h3C);

    // Loopback: program write, memory write, then read back.
    frame(1'b0, 2'b00, 8'h20, ssel_low, rises, rsp_at, accept_next, sck_period);
    frame(1'b0, 2'b01, 8'h5A, ssel_low, rises, rsp_at, accept_next, sck_period);
    frame(1'b0, 2'b00, 8'h10, ssel_low, rises, rsp_at, accept_next, sck_period);
    frame(1'b0, 2'b11, 8'h77, ssel_low, rises, rsp_at, accept_next, sck_period);
    frame(1'b0, 2'b00, 8'h10, ssel_low, rises, rsp_at, accept_next, sck_period);
    frame(1'b0, 2'b10, 8'h00, ssel_low, rises, rsp_at, accept_next, sck_period);
    check("loopback_rsp", rsp_data_a, 8'h77);
    check("loopback_mem", dev_mem[8'h10], 8'h77);
    check("loopback_prog", dev_prog[8'h20], 8'h5A);
    check("rsp_data_held", rsp_data_a, 8'h77);

    // Back-to-back with cmd_valid held high for four commands.
    wait_ready(1'b0);
    min_gap = 1000;
    cmd_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1'b0);
      cmd_op   = 2'(i);
      cmd_data = 8'(8'h30 + 8'(i * 17));
      push_expect(1'b0, cmd_op, cmd_data);
      @(posedge clk);
      acc_t[i] = $time;
      @(negedge clk);
    end
    cmd_valid_a = 1'b0;
    wait_ready(1'b0);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_accept_spacing_%0d", i), 32'((acc_t[i] - acc_t[i-1]) / 10), 184);
    check("b2b_min_ssel_gap_ge16", min_gap >= 16, 1);

    // Mid-frame reset while SCK is high: abort without any response.
    cmd_op = 2'b10;
    cmd_data = 8'h00;
    cmd_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    repeat (59) @(posedge clk);
    #2;
    check("abort_sck_high_before", sck_a, 1);
    reset_n = 1'b0;
    #1;
    check("abort_ssel_async", ssel_a, 1);
    check("abort_sck_async", sck_a, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready_a, 1);
    check("abort_rsp_valid", rsp_valid_a, 0);
    repeat (200) @(negedge clk);
    check("abort_rsp_count", n_rsp_a, n_exp_a);

    // Fast parameter set with a late-answering device.
    frame(1'b1, 2'b10, 8'h00, ssel_low, rises, rsp_at, accept_next, sck_period);
    check("fast_sck_rises", rises, 10);
    check("fast_sck_period", sck_period, 8);
    check("fast_ssel_low_cycles", ssel_low, 82);
    check("fast_rsp_valid_at", rsp_at, 82);
    check("fast_next_accept_edge", accept_next, 86);
    check("fast_rsp_data", rsp_data_b, DEV_B_BYTE);
    frame(1'b1, 2'b11, 8'h6E, ssel_low, rises, rsp_at, accept_next, sck_period);
    repeat (4) @(negedge clk);

    check("rsp_count_a", n_rsp_a, n_exp_a);
    check("rsp_count_b", n_rsp_b, n_exp_b);
    check("scoreboard_a_empty", q_rsp_a.size() + q_word_a.size(), 0);
    check("scoreboard_b_empty", q_rsp_b.size() + q_word_b.size(), 0);
    check("device_addr", dev_addr, ref_addr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
